lfsr_checker: RTL

- Receive-side counterpart of the 32-bit LFSR pattern generator. Consumes a stream of LFSR state words over a valid/ready handshake.
- Self-synchronises by seeding its own LFSR from the incoming data, then verifies every following word against the predicted next state.
- Reports lock status, per-word error pulses and saturating error/word counters.
- Sits between the generator (or a UDM-fed bus path) and CSR readback, for link and pattern self-test.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/sat_counter.sv | 22 ++
 rtl/lfsr_checker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR pattern generator and checker.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // One Fibonacci shift: feedback is the parity of the tapped bits.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s,
                                                      input logic [LFSR_WIDTH-1:0] taps);
    lfsr_step = {s[LFSR_WIDTH-2:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR pattern checker: self-seeds from the stream, verifies,
// locks, and counts words and in-lock mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned     WIDTH           = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS           = WIDTH'(LFSR_TAPS),
  parameter int unsigned     LOCK_MATCHES    = 4,
  parameter int unsigned     LOSS_MISMATCHES = 3,
  parameter int unsigned     CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_LIM = RUN_W'(LOCK_MATCHES);
  localparam logic [RUN_W-1:0] LOSS_LIM = RUN_W'(LOSS_MISMATCHES);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    step = {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  chk_state_e       state;
  logic [RUN_W-1:0] match_cnt;
  logic [RUN_W-1:0] miss_cnt;

  logic             accept;
  logic             hit;
  logic             data_zero;
  logic             err_inc;
  logic [WIDTH-1:0] step_exp;
  logic [WIDTH-1:0] step_in;
  logic [RUN_W-1:0] match_inc;
  logic [RUN_W-1:0] miss_inc;

  assign accept    = in_valid & in_ready;
  assign hit       = (in_data == expected);
  assign data_zero = (in_data == '0);
  assign step_exp  = step(expected);
  assign step_in   = step(in_data);
  assign match_inc = match_cnt + RUN_W'(1);
  assign miss_inc  = miss_cnt + RUN_W'(1);
  assign err_inc   = accept & (state == LOCKED) & ~hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready  <= 1'b1;
      err_pulse <= 1'b0;
      if (accept) begin
        case (state)
          HUNT: begin
            // Zero is the LFSR lockup value and can never seed a stream.
            if (!data_zero) begin
              expected  <= step_in;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              expected  <= step_exp;
              match_cnt <= match_inc;
              if (match_inc == LOCK_LIM) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (!data_zero) begin
              expected  <= step_in;
              match_cnt <= '0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            // Free-running prediction: one bad word costs exactly one error.
            expected <= step_exp;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              miss_cnt  <= miss_inc;
              if (miss_inc == LOSS_LIM) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clr),
    .cnt (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .clr (clr),
    .cnt (word_cnt)
  );

endmodule
